// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: request side drives start and
// operands, the adder returns busy/done and the registered sum/carry.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input  busy, done, sum, cout);
  modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, one bit pair
// per clock LSB first; result and final carry are published with a done strobe.
module fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic ca
);
  assign s  = a ^ b ^ c;
  assign ca = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aShift;
  logic [WIDTH-1:0] r_bShift;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_count;
  logic             w_s;
  logic             w_ca;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_resultWide;
  logic [WIDTH-1:0] w_resultNext;

  fa u_fa (
    .a  (r_aShift[0]),
    .b  (r_bShift[0]),
    .c  (r_carry),
    .s  (w_s),
    .ca (w_ca)
  );

  // Widening before the shift keeps the MSB insertion legal even for WIDTH=1.
  assign w_resultWide = {w_s, r_result};
  assign w_resultNext = w_resultWide[WIDTH:1];

  assign w_accept = bus.start && (r_state != SHIFT);
  assign w_last   = (r_state == SHIFT) && (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = SHIFT;
      SHIFT:   if (w_last) w_nextState = DONE;
      DONE:    w_nextState = bus.start ? SHIFT : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aShift <= '0;
      r_bShift <= '0;
      r_result <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_aShift <= bus.a;
      r_bShift <= bus.b;
      r_carry  <= bus.cin;
      r_count  <= '0;
    end else if (r_state == SHIFT) begin
      r_aShift <= r_aShift >> 1;
      r_bShift <= r_bShift >> 1;
      r_result <= w_resultNext;
      r_carry  <= w_ca;
      r_count  <= r_count + CW'(1);
      // Publish only on the final bit so sum/cout never show partial results.
      if (w_last) begin
        r_sum  <= w_resultNext;
        r_cout <= w_ca;
      end
    end
  end

  assign bus.busy = (r_state == SHIFT);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus queues expected {cout,sum}, monitors
// pop and compare on every done strobe of the WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder;
  logic clk;
  logic rst_n;
  int   passCount;
  int   totalCount;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitors compare every done against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (if8.done) begin
      checkOutput("done8_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) checkOutput("result8", {23'd0, if8.cout, if8.sum}, {23'd0, q8.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (if1.done) begin
      checkOutput("done1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) checkOutput("result1", {30'd0, if1.cout, if1.sum}, {30'd0, q1.pop_front()});
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                               input logic [8:0] exp, input bit expectDone);
    @(negedge clk);
    if8.a     = a;
    if8.b     = b;
    if8.cin   = cin;
    if8.start = 1'b1;
    if (expectDone) q8.push_back(exp);
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  // Called right after applyStimulus; watches busy/done shape over a bounded window.
  task automatic watchPulse(input string name, input int expBusy);
    int busyCycles;
    int doneCycles;
    busyCycles = 0;
    doneCycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      if (if8.busy) busyCycles++;
      if (if8.done) doneCycles++;
    end
    checkOutput({name, "_busy_cycles"}, 32'(busyCycles), 32'(expBusy));
    checkOutput({name, "_done_pulses"}, 32'(doneCycles), 32'd1);
  endtask

  initial begin
    int doneCount;
    int d1;
    int d2;
    passCount  = 0;
    totalCount = 0;
    rst_n      = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset8", {22'd0, if8.busy, if8.done, if8.cout, if8.sum}, 32'd0);
    checkOutput("reset1", {28'd0, if1.busy, if1.done, if1.cout, if1.sum}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(8'h5A, 8'h33, 1'b0, 9'h08D, 1'b1);
    watchPulse("op5A33", 8);

    applyStimulus(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    watchPulse("opFF01", 8);

    applyStimulus(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1);
    watchPulse("opFFFF", 8);
    if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("hold_after_operand_change", {23'd0, if8.cout, if8.sum}, 32'h1FF);

    // Second start mid-SHIFT with new operands must be ignored.
    applyStimulus(8'h12, 8'h34, 1'b0, 9'h046, 1'b1);
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'hAA;
    @(negedge clk);
    if8.start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (if8.done) doneCount++;
    end
    checkOutput("ignored_start_done_pulses", 32'(doneCount), 32'd1);

    // Abort at the fourth SHIFT cycle; no expectation is queued for it.
    applyStimulus(8'h77, 8'h11, 1'b0, 9'h000, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("busy_before_abort", 32'(if8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs", {22'd0, if8.busy, if8.done, if8.cout, if8.sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h10, 8'h20, 1'b0, 9'h030, 1'b1);
    watchPulse("after_abort", 8);

    // Back-to-back, WIDTH=8: start held through the DONE cycle.
    @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h5A; if8.b = 8'h33; if8.cin = 1'b0;
    q8.push_back(9'h08D);
    @(negedge clk);
    if8.a = 8'h0F; if8.b = 8'hF0; if8.cin = 1'b1;
    q8.push_back(9'h100);
    d1 = -1; d2 = -1;
    for (int i = 0; i < 40; i++) begin
      if (i != 0) @(negedge clk);
      if (if8.done) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
      if (d1 >= 0 && i == d1 + 1) if8.start = 1'b0;
    end
    if8.start = 1'b0;
    checkOutput("b2b8_first_done_seen", 32'(d1 >= 0), 32'd1);
    checkOutput("b2b8_spacing", 32'(d2 - d1), 32'd9);

    // Back-to-back, WIDTH=1.
    @(negedge clk);
    if1.start = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
    q1.push_back(2'b11);
    @(negedge clk);
    checkOutput("w1_busy", 32'(if1.busy), 32'd1);
    if1.a = 1'b0; if1.b = 1'b1; if1.cin = 1'b0;
    q1.push_back(2'b01);
    d1 = -1; d2 = -1;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      if (if1.done) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
      if (d1 >= 0 && i == d1 + 1) if1.start = 1'b0;
    end
    if1.start = 1'b0;
    checkOutput("b2b1_first_done_seen", 32'(d1 >= 0), 32'd1);
    checkOutput("b2b1_spacing", 32'(d2 - d1), 32'd2);

    repeat (4) @(negedge clk);
    checkOutput("q8_drained", 32'(q8.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end
endmodule
